spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI peripheral. It sits between the TX/RX FIFOs and the SPI pins and runs one transfer per word:
- pops a word from the TX FIFO;
- asserts the selected chip select;
- generates `spi_clk` edges from the baud-rate divider tick in the per-channel SPI mode;
- shifts the word out MSB-first while sampling `spi_rx`, then pushes the received word into the RX FIFO.

All configuration comes straight from the control register fields (word size, CS auto/enable, CS select, enable, per-channel mode).

---
 rtl/spi_xfer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// spi_xfer_ctrl : one SPI transfer per TX FIFO word, result pushed to RX FIFO
// Revision      : 1.0
// ============================================================================
module spi_xfer_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [4:0]        word_size,
   input  logic [3:0]        cs_auto,
   input  logic [3:0]        cs_enable,
   input  logic [1:0]        cs_select,
   input  logic [7:0]        mode,
   input  logic              baud_tick,
   input  logic              tx_empty,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_pop,
   input  logic              rx_full,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_push,
   output logic              rx_ovf,
   output logic              spi_clk,
   output logic              spi_tx,
   input  logic              spi_rx,
   output logic [3:0]        spi_cs_n,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_PUSH  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   txsr_q, txsr_d;
   logic [DATA_W-1:0]   rxsr_q, rxsr_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic [4:0]          nm1_q, nm1_d;
   logic [1:0]          sel_q, sel_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic [5:0]          edge_q, edge_d;
   logic                spi_clk_q, spi_clk_d;
   logic                spi_tx_q, spi_tx_d;
   logic [3:0]          cs_n_q, cs_n_d;
   logic                busy_q, busy_d;

   logic                w_start;
   logic                w_cpol_sel;
   logic                w_cpha_sel;
   logic [DATA_W-1:0]   w_aligned;
   logic                w_last;
   logic                w_sample;
   logic                w_drive;
   logic                w_xfer_d;

   assign w_start    = (state_q == S_IDLE) && enable && !tx_empty && !reset;
   assign w_cpol_sel = mode[{cs_select, 1'b1}];
   assign w_cpha_sel = mode[{cs_select, 1'b0}];
   // Left-align the N-bit word so MOSI always comes from the shift register MSB.
   assign w_aligned  = tx_data << (5'd31 - word_size);
   // edge_q is the zero-based index of the edge the next tick generates.
   assign w_last     = (edge_q == {nm1_q, 1'b1});
   assign w_sample   = (edge_q[0] == cpha_q);
   assign w_drive    = cpha_q ? (!edge_q[0] && (edge_q != 6'd0))
                              : (edge_q[0] && !w_last);

   always_comb begin
      state_d   = state_q;
      txsr_d    = txsr_q;
      rxsr_d    = rxsr_q;
      rx_data_d = rx_data_q;
      nm1_d     = nm1_q;
      sel_d     = sel_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      edge_d    = edge_q;
      spi_clk_d = spi_clk_q;
      spi_tx_d  = spi_tx_q;
      cs_n_d    = 4'hF;
      w_xfer_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            spi_clk_d = w_cpol_sel;
            if (w_start) begin
               state_d  = S_SETUP;
               nm1_d    = word_size;
               sel_d    = cs_select;
               cpol_d   = w_cpol_sel;
               cpha_d   = w_cpha_sel;
               spi_tx_d = w_aligned[DATA_W-1];
               txsr_d   = w_aligned << 1;
               rxsr_d   = '0;
               edge_d   = '0;
            end
         end
         S_SETUP, S_SHIFT: begin
            if (baud_tick) begin
               spi_clk_d = ~spi_clk_q;
               edge_d    = edge_q + 6'd1;
               if (w_sample) begin
                  rxsr_d = {rxsr_q[DATA_W-2:0], spi_rx};
               end
               if (w_drive) begin
                  spi_tx_d = txsr_q[DATA_W-1];
                  txsr_d   = txsr_q << 1;
               end
               if (state_q == S_SETUP) begin
                  state_d = S_SHIFT;
               end else if (w_last) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (baud_tick) begin
               state_d   = S_PUSH;
               rx_data_d = rxsr_q;
            end
         end
         S_PUSH: begin
            state_d = S_GAP;
         end
         S_GAP: begin
            if (baud_tick) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Losing enable abandons the word outright: no push, clock parked at CPOL.
      if ((state_q != S_IDLE) && !enable) begin
         state_d   = S_IDLE;
         spi_clk_d = cpol_q;
         rx_data_d = rx_data_q;
      end

      w_xfer_d = (state_d == S_SETUP) || (state_d == S_SHIFT) ||
                 (state_d == S_HOLD)  || (state_d == S_PUSH);
      for (int i = 0; i < 4; i++) begin
         cs_n_d[i] = cs_auto[i] ? !(w_xfer_d && (sel_d == 2'(i))) : !cs_enable[i];
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         txsr_q    <= '0;
         rxsr_q    <= '0;
         rx_data_q <= '0;
         nm1_q     <= '0;
         sel_q     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         edge_q    <= '0;
         spi_clk_q <= 1'b0;
         spi_tx_q  <= 1'b0;
         cs_n_q    <= 4'hF;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         txsr_q    <= txsr_d;
         rxsr_q    <= rxsr_d;
         rx_data_q <= rx_data_d;
         nm1_q     <= nm1_d;
         sel_q     <= sel_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         edge_q    <= edge_d;
         spi_clk_q <= spi_clk_d;
         spi_tx_q  <= spi_tx_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_pop   = w_start;
   assign rx_push  = (state_q == S_PUSH) && enable && !rx_full;
   assign rx_ovf   = (state_q == S_PUSH) && enable && rx_full;
   assign rx_data  = rx_data_q;
   assign spi_clk  = spi_clk_q;
   assign spi_tx   = spi_tx_q;
   assign spi_cs_n = cs_n_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_xfer_ctrl : directed self-checking bench for spi_xfer_ctrl
// Revision         : 1.0
// ============================================================================
module tb_spi_xfer_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [4:0]  word_size;
   logic [3:0]  cs_auto;
   logic [3:0]  cs_enable;
   logic [1:0]  cs_select;
   logic [7:0]  mode;
   logic        baud_tick = 1'b0;
   logic        rx_full;
   logic        loop_en = 1'b0;
   logic        tx_empty;
   logic [31:0] tx_data;
   logic        tx_pop;
   logic [31:0] rx_data;
   logic        rx_push;
   logic        rx_ovf;
   logic        spi_clk;
   logic        spi_tx;
   logic        spi_rx;
   logic [3:0]  spi_cs_n;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Show-ahead TX FIFO model
   logic [31:0] tx_mem [0:31];
   logic [4:0]  tx_wr = '0;
   logic [4:0]  tx_rd = '0;
   assign tx_empty = (tx_wr == tx_rd);
   assign tx_data  = tx_mem[tx_rd];
   always @(posedge clk) if (tx_pop) tx_rd <= tx_rd + 5'd1;

   assign spi_rx = loop_en ? spi_tx : 1'b0;

   int tick_per = 1;
   int tick_cnt = 0;
   always @(negedge clk) begin
      if (tick_per <= 1) baud_tick = 1'b1;
      else begin
         baud_tick = (tick_cnt == 0);
         tick_cnt  = (tick_cnt + 1) % tick_per;
      end
   end

   always #5 clk = ~clk;

   spi_xfer_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .enable(enable), .word_size(word_size),
      .cs_auto(cs_auto), .cs_enable(cs_enable), .cs_select(cs_select),
      .mode(mode), .baud_tick(baud_tick), .tx_empty(tx_empty),
      .tx_data(tx_data), .tx_pop(tx_pop), .rx_full(rx_full),
      .rx_data(rx_data), .rx_push(rx_push), .rx_ovf(rx_ovf),
      .spi_clk(spi_clk), .spi_tx(spi_tx), .spi_rx(spi_rx),
      .spi_cs_n(spi_cs_n), .busy(busy)
   );

   task automatic push_word(input logic [31:0] w);
      tx_mem[tx_wr] = w;
      tx_wr = tx_wr + 5'd1;
   endtask

   task automatic wait_pop(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         #1;
         if (tx_pop === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; word_size = 5'd7; cs_auto = 4'hF;
      cs_enable = 4'h0; cs_select = 2'd0; mode = 8'h00; rx_full = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (spi_cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs: got %h expected f", spi_cs_n); end
      checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", spi_clk); end
      checks++; if (spi_tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b expected 0", spi_tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0", rx_data); end
      checks++; if ({tx_pop, rx_push, rx_ovf} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {tx_pop, rx_push, rx_ovf}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode0_loopback();
      bit ok;
      logic       clkv [0:21];
      logic       txv  [0:21];
      logic [3:0] csv  [0:21];
      logic       pushv[0:21];
      logic [31:0] datav[0:21];
      int tin, tout, npush, pidx;
      logic [7:0] mb;
      mode = 8'h00; cs_select = 2'd0; cs_auto = 4'b0001; cs_enable = 4'h0;
      word_size = 5'd7; tick_per = 1; loop_en = 1'b1; rx_full = 1'b0;
      @(negedge clk);
      push_word(32'hA5);
      enable = 1'b1;
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL m0_pop: got no tx_pop expected one within 10 cycles"); end
      clkv[0] = spi_clk;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         clkv[k] = spi_clk; txv[k] = spi_tx; csv[k] = spi_cs_n;
         pushv[k] = rx_push; datav[k] = rx_data;
      end
      checks++; if (csv[1] !== 4'b1110) begin errors++; $display("FAIL m0_cs_low: got %b expected 1110", csv[1]); end
      tin = 0; tout = 0;
      for (int k = 1; k <= 21; k++)
         if (clkv[k] !== clkv[k-1]) begin
            if (k >= 2 && k <= 17) tin++; else tout++;
         end
      checks++; if (tin != 16 || tout != 0) begin errors++; $display("FAIL m0_edges: got %0d in-window %0d outside expected 16 and 0", tin, tout); end
      mb = '0;
      for (int i = 0; i < 8; i++) mb = {mb[6:0], txv[2 + 2*i]};
      checks++; if (mb !== 8'hA5) begin errors++; $display("FAIL m0_mosi: got %h expected a5", mb); end
      npush = 0; pidx = -1;
      for (int k = 1; k <= 21; k++) if (pushv[k] === 1'b1) begin npush++; pidx = k; end
      checks++; if (npush != 1 || pidx != 18) begin errors++; $display("FAIL m0_push_time: got %0d pushes last at T+%0d expected 1 at T+18", npush, pidx); end
      checks++; if (datav[18] !== 32'h0000_00A5) begin errors++; $display("FAIL m0_rx_data: got %h expected 000000a5", datav[18]); end
      checks++; if (csv[19] !== 4'hF) begin errors++; $display("FAIL m0_cs_high: got %b expected 1111", csv[19]); end
   endtask

   task automatic test_mode3_full();
      bit ok, got, csbad;
      logic prev;
      int edges;
      logic [31:0] data;
      mode = 8'h03; cs_select = 2'd0; cs_auto = 4'b0001; word_size = 5'd31;
      tick_per = 4;
      repeat (3) @(negedge clk);
      checks++; if (spi_clk !== 1'b1) begin errors++; $display("FAIL m3_idle_clk: got %b expected 1", spi_clk); end
      push_word(32'hDEADBEEF);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL m3_pop: got no tx_pop expected one within 10 cycles"); end
      prev = spi_clk; edges = 0; got = 1'b0; csbad = 1'b0; data = '0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (spi_clk !== prev) begin
            edges++;
            if (spi_cs_n[0] !== 1'b0) csbad = 1'b1;
         end
         prev = spi_clk;
         if (rx_push === 1'b1) begin got = 1'b1; data = rx_data; end
         if (got && spi_cs_n[0] === 1'b1) break;
      end
      checks++; if (!got) begin errors++; $display("FAIL m3_push: got no rx_push expected one within 400 cycles"); end
      checks++; if (edges != 64) begin errors++; $display("FAIL m3_edges: got %0d expected 64", edges); end
      checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL m3_rx_data: got %h expected deadbeef", data); end
      checks++; if (csbad || spi_clk !== 1'b1) begin errors++; $display("FAIL m3_cs_clk: got csbad=%b clk=%b expected 0 and 1", csbad, spi_clk); end
      tick_per = 1;
      @(negedge clk);
   endtask

   task automatic test_rx_full();
      bit ok;
      int npush, novf, oidx;
      logic b19, b20;
      logic [3:0] c19;
      mode = 8'h00; word_size = 5'd7; rx_full = 1'b1;
      @(negedge clk);
      push_word(32'h3C);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_pop: got no tx_pop expected one within 10 cycles"); end
      npush = 0; novf = 0; oidx = -1; b19 = 1'b0; b20 = 1'b1; c19 = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rx_push === 1'b1) npush++;
         if (rx_ovf === 1'b1) begin novf++; oidx = k; end
         if (k == 19) begin b19 = busy; c19 = spi_cs_n; end
         if (k == 20) b20 = busy;
      end
      checks++; if (novf != 1 || oidx != 18) begin errors++; $display("FAIL full_ovf: got %0d pulses last at T+%0d expected 1 at T+18", novf, oidx); end
      checks++; if (npush != 0) begin errors++; $display("FAIL full_no_push: got %0d expected 0", npush); end
      checks++; if (b19 !== 1'b1 || b20 !== 1'b0 || c19 !== 4'hF) begin errors++; $display("FAIL full_gap: got busy19=%b busy20=%b cs19=%b expected 1 0 1111", b19, b20, c19); end
      rx_full = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok, was_low, other_bad;
      int pop2, npush, run, gap;
      logic [31:0] d [0:1];
      cs_select = 2'd2; cs_auto = 4'b0100; cs_enable = 4'b1010; mode = 8'h10;
      word_size = 5'd7; loop_en = 1'b1;
      repeat (2) @(negedge clk);
      push_word(32'h5A);
      push_word(32'hC3);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_pop: got no tx_pop expected one within 10 cycles"); end
      pop2 = -1; npush = 0; run = 0; gap = 0; was_low = 1'b0; other_bad = 1'b0;
      d[0] = '0; d[1] = '0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (tx_pop === 1'b1 && pop2 < 0) pop2 = k;
         if (rx_push === 1'b1) begin
            if (npush < 2) d[npush] = rx_data;
            npush++;
         end
         if ((spi_cs_n & 4'b1011) !== 4'b0001) other_bad = 1'b1;
         if (spi_cs_n[2] === 1'b0) begin
            if (was_low && run > 0 && gap == 0) gap = run;
            was_low = 1'b1;
         end else if (was_low) run++;
      end
      checks++; if (pop2 != 20) begin errors++; $display("FAIL b2b_pop2: got T+%0d expected T+20", pop2); end
      checks++; if (npush != 2 || d[0] !== 32'h5A) begin errors++; $display("FAIL b2b_word1: got %0d pushes first %h expected 2 and 5a", npush, d[0]); end
      checks++; if (d[1] !== 32'hC3) begin errors++; $display("FAIL b2b_word2: got %h expected c3", d[1]); end
      checks++; if (gap != 2) begin errors++; $display("FAIL b2b_cs_gap: got %0d cycles expected 2", gap); end
      checks++; if (other_bad) begin errors++; $display("FAIL b2b_manual_cs: got a deviation expected channels 0,1,3 at 1,0,0"); end
   endtask

   task automatic test_abort();
      bit ok;
      int bad;
      cs_select = 2'd0; cs_auto = 4'b0001; cs_enable = 4'h0; mode = 8'h00;
      word_size = 5'd7;
      @(negedge clk);
      push_word(32'h81);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_pop: got no tx_pop expected one within 10 cycles"); end
      repeat (6) @(negedge clk);
      checks++; if (spi_clk !== 1'b1) begin errors++; $display("FAIL abort_edge5: got clk %b expected 1", spi_clk); end
      enable = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || spi_cs_n !== 4'hF || spi_clk !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b cs=%b clk=%b expected 0 1111 0", busy, spi_cs_n, spi_clk); end
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (rx_push === 1'b1 || rx_ovf === 1'b1 || tx_pop === 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_push: got %0d strobes expected 0", bad); end
   endtask

   task automatic test_async_reset();
      bit ok;
      int pidx;
      logic [31:0] pdata;
      cs_select = 2'd0; cs_auto = 4'b0001; mode = 8'h00; word_size = 5'd7;
      enable = 1'b1;
      @(negedge clk);
      push_word(32'h96);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL arst_pop: got no tx_pop expected one within 10 cycles"); end
      repeat (4) @(negedge clk);
      checks++; if (spi_clk !== 1'b1 || spi_cs_n[0] !== 1'b0) begin errors++; $display("FAIL arst_pre: got clk=%b cs0=%b expected 1 0", spi_clk, spi_cs_n[0]); end
      #2 reset = 1'b1;
      #1;
      checks++; if (spi_clk !== 1'b0 || spi_cs_n !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL arst_outputs: got clk=%b cs=%b busy=%b expected 0 1111 0", spi_clk, spi_cs_n, busy); end
      checks++; if (rx_data !== 32'h0 || spi_tx !== 1'b0) begin errors++; $display("FAIL arst_data: got rx_data=%h tx=%b expected 0 0", rx_data, spi_tx); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push_word(32'h69);
      wait_pop(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL arst_repop: got no tx_pop expected one within 10 cycles"); end
      pidx = -1; pdata = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rx_push === 1'b1) begin pidx = k; pdata = rx_data; end
      end
      checks++; if (pidx != 18 || pdata !== 32'h69) begin errors++; $display("FAIL arst_after: got push at T+%0d data %h expected T+18 and 69", pidx, pdata); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_mode0_loopback();
      test_mode3_full();
      test_rx_full();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
